// File: rtl/morse_symbolizer.sv
// Morse key level to symbol stream (DOT/DASH/LETTER_END/WORD_END) through a 2-entry valid/ready FIFO.
// Optional MORSE_GLITCH_REJECT_EN: presses shorter than GLITCH_TICKS are discarded instead of classified.
module morse_symbolizer #(
  parameter int DASH_TICKS       = 24,
  parameter int LETTER_GAP_TICKS = 36,
  parameter int WORD_GAP_TICKS   = 84,
  parameter int GLITCH_TICKS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_i,
  input  logic       ready_i,
  output logic [1:0] symbol_o,
  output logic       valid_o,
  output logic       letter_pending_o,
  output logic       overflow_o
);
  localparam int CW = $clog2(WORD_GAP_TICKS + 1);
  localparam logic [CW-1:0] DASH_C = CW'(DASH_TICKS);
  localparam logic [CW-1:0] WG_C   = CW'(WORD_GAP_TICKS);
  localparam logic [CW:0]   LG_N   = (CW+1)'(LETTER_GAP_TICKS);
  localparam logic [CW:0]   WG_N   = (CW+1)'(WORD_GAP_TICKS);

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LEND = 2'b10;
  localparam logic [1:0] SYM_WEND = 2'b11;

  if (WORD_GAP_TICKS <= DASH_TICKS || WORD_GAP_TICKS <= LETTER_GAP_TICKS ||
      LETTER_GAP_TICKS < 2 || GLITCH_TICKS < 1) begin : g_bad_params
    $error("morse_symbolizer: inconsistent tick thresholds");
  end

  typedef enum logic [1:0] {IDLE, PRESS, GAP, LGAP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_lp;
  logic [1:0]      r_mem [0:1];
  logic [1:0]      r_cnt;
  logic            r_ovf;

  logic [CW:0]     w_next;
  logic [CW-1:0]   w_inc;
  logic            w_glitch;
  logic            w_push;
  logic [1:0]      w_sym;
  logic            w_pop;

  // w_next is the length of the current run including this sample
  assign w_next = {1'b0, r_count} + 1'b1;
  assign w_inc  = (r_count == WG_C) ? r_count : r_count + 1'b1;

`ifdef MORSE_GLITCH_REJECT_EN
  assign w_glitch = (r_count < CW'(GLITCH_TICKS));
`else
  assign w_glitch = 1'b0;
`endif

  always_comb begin
    w_push = 1'b0;
    w_sym  = SYM_DOT;
    if (!key_i) begin
      case (r_state)
        PRESS: if (!w_glitch) begin
          w_push = 1'b1;
          w_sym  = (r_count < DASH_C) ? SYM_DOT : SYM_DASH;
        end
        GAP:  if (w_next == LG_N) begin w_push = 1'b1; w_sym = SYM_LEND; end
        LGAP: if (w_next == WG_N) begin w_push = 1'b1; w_sym = SYM_WEND; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_lp    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (key_i) begin
          r_state <= PRESS;
          r_count <= CW'(1);
        end
        PRESS: begin
          if (key_i) begin
            r_count <= w_inc;
          end else if (w_glitch) begin
            // a rejected blip inside a letter keeps timing the gap; otherwise the line is idle
            r_state <= r_lp ? GAP : IDLE;
            r_count <= CW'(1);
          end else begin
            r_lp    <= 1'b1;
            r_state <= GAP;
            r_count <= CW'(1);
          end
        end
        GAP: begin
          if (key_i) begin
            r_state <= PRESS;
            r_count <= CW'(1);
          end else begin
            r_count <= w_inc;
            if (w_next == LG_N) begin
              r_lp    <= 1'b0;
              r_state <= LGAP;
            end
          end
        end
        LGAP: begin
          if (key_i) begin
            r_state <= PRESS;
            r_count <= CW'(1);
          end else if (w_next == WG_N) begin
            r_state <= IDLE;
          end else begin
            r_count <= w_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_pop = (r_cnt != 2'd0) && ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= SYM_DOT;
      r_mem[1] <= SYM_DOT;
      r_cnt    <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_cnt    <= r_cnt - 2'd1;
        end
        2'b10: begin
          if (r_cnt == 2'd2) begin
            r_ovf <= 1'b1;
          end else begin
            r_mem[r_cnt[0]] <= w_sym;
            r_cnt           <= r_cnt + 2'd1;
          end
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= w_sym;
          end else begin
            r_mem[0] <= w_sym;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o          = (r_cnt != 2'd0);
  assign symbol_o         = valid_o ? r_mem[0] : SYM_DOT;
  assign letter_pending_o = r_lp;
  assign overflow_o       = r_ovf;

endmodule

// File: tb/tb_morse_symbolizer.sv
// Bench for morse_symbolizer: constant-expectation vector tables, directed sequences and
// randomized key/ready traffic checked against a run-length reference model.
module tb_morse_symbolizer;
  localparam int DASH = 4, LG = 6, WG = 14, GL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [1:0] symbol_o;
  logic       valid_o, letter_pending_o, overflow_o;

  int total = 0;
  int bad   = 0;

  morse_symbolizer #(.DASH_TICKS(DASH), .LETTER_GAP_TICKS(LG), .WORD_GAP_TICKS(WG),
                     .GLITCH_TICKS(GL)) dut (
    .clk(clk), .reset(reset), .key_i(key_i), .ready_i(ready_i),
    .symbol_o(symbol_o), .valid_o(valid_o),
    .letter_pending_o(letter_pending_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  // reference model: lengths of the current press and of the zero run that follows it
  int m_plen, m_zrun;
  bit m_active, m_pend, m_ovf;
  int m_q[$];

  task automatic model_edge(input bit k, input bit r, input bit rs);
    bit pop, push;
    int sym;
    if (rs) begin
      m_plen = 0; m_zrun = 0; m_active = 0; m_pend = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    pop = (m_q.size() > 0) && r;
    push = 0; sym = 0;
    if (k) begin
      m_plen++;
      m_zrun = 0;
    end else if (m_plen > 0) begin
      m_zrun = 1;
`ifdef MORSE_GLITCH_REJECT_EN
      if (m_plen < GL) begin
        m_active = m_pend;
      end else
`endif
      begin
        push = 1; sym = (m_plen < DASH) ? 0 : 1;
        m_pend = 1; m_active = 1;
      end
      m_plen = 0;
    end else if (m_active) begin
      m_zrun++;
      if (m_zrun == LG) begin push = 1; sym = 2; m_pend = 0; end
      if (m_zrun == WG) begin push = 1; sym = 3; m_active = 0; end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(sym);
      else m_ovf = 1;
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    cmp("valid", int'(valid_o), int'(m_q.size() > 0));
    cmp("symbol", int'(symbol_o), (m_q.size() > 0) ? m_q[0] : 0);
    cmp("letter_pending", int'(letter_pending_o), int'(m_pend));
    cmp("overflow", int'(overflow_o), int'(m_ovf));
  endtask

  task automatic step(input bit k, input bit r, input bit rs);
    key_i = k; ready_i = r; reset = rs;
    @(posedge clk);
    model_edge(k, r, rs);
    #1;
    check_model();
  endtask

  task automatic run(input bit k, input int n, input bit r);
    for (int i = 0; i < n; i++) step(k, r, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
  endtask

  typedef struct {
    bit       key, ready, rst;
    bit       valid;
    bit [1:0] sym;
    bit       lp, ovf;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit k, input bit r, input bit rs, input bit v,
                     input bit [1:0] s, input bit lp, input bit ov, input int n);
    vec_t e;
    e.key = k; e.ready = r; e.rst = rs; e.valid = v; e.sym = s; e.lp = lp; e.ovf = ov;
    for (int i = 0; i < n; i++) vt.push_back(e);
  endtask

  initial begin
    // test 1: 3-edge press then 20 zeros with ready high
    add(0, 1, 1, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 1, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 4);
    add(0, 1, 0, 1, 2, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 7);
    add(0, 1, 0, 1, 3, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 6);
    // test 4: ready low, DOT and DASH held, third DOT dropped, then drain
    add(0, 1, 1, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0, 4);
    add(0, 0, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 0, 1, 0, 1, 1, 1);
    add(0, 1, 0, 1, 1, 1, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].key, vt[i].ready, vt[i].rst);
      cmp("tbl_valid", int'(valid_o), int'(vt[i].valid));
      if (vt[i].valid) cmp("tbl_symbol", int'(symbol_o), int'(vt[i].sym));
      cmp("tbl_letter_pending", int'(letter_pending_o), int'(vt[i].lp));
      cmp("tbl_overflow", int'(overflow_o), int'(vt[i].ovf));
    end

    // test 2: DASH_TICKS boundary, short gaps never reach LETTER_END
    do_reset();
    run(1, 4, 1); run(0, 2, 1);
    run(1, 3, 1); run(0, 2, 1);
    run(1, 5, 1); run(0, 20, 1);

    // test 3: gap of 5 stays in the letter, gap of 6 ends it
    do_reset();
    run(1, 3, 1); run(0, 5, 1);
    cmp("t3_pending_mid", int'(letter_pending_o), 1);
    run(1, 3, 1); run(0, 6, 1);
    cmp("t3_pending_end", int'(letter_pending_o), 0);
    run(0, 10, 1);

    // test 5: reset on the 2nd edge of a press abandons it
    do_reset();
    step(1, 1, 0);
    step(1, 1, 1);
    cmp("t5_valid_rst", int'(valid_o), 0);
    cmp("t5_pending_rst", int'(letter_pending_o), 0);
    run(0, 20, 1);
    cmp("t5_valid_after", int'(valid_o), 0);

    // test 6: single-edge press
    do_reset();
    run(1, 1, 1);
    step(0, 1, 0);
`ifdef MORSE_GLITCH_REJECT_EN
    cmp("t6_valid", int'(valid_o), 0);
`else
    cmp("t6_valid", int'(valid_o), 1);
    cmp("t6_symbol", int'(symbol_o), 0);
`endif
    run(0, 19, 1);

    // saturation: very long press and very long idle line
    do_reset();
    run(1, 40, 1); run(0, 40, 1);

    // randomized runs with back-pressure and rare resets
    do_reset();
    for (int n = 0; n < 300; n++) begin
      bit lvl;
      int len;
      lvl = n[0];
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        step(lvl, ($urandom % 4) != 0, ($urandom % 400) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1);
  end
endmodule
